button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//  Turns one raw, bouncy push-button input into a clean debounced level plus
//  single-cycle gesture events: press, release, click, double-click, long press.
//  Sits between the board button pins and the watch mode/set FSMs.
//  Complements the auto-repeat rebouncer: rebouncer generates pulse trains from
//  a held level; this block interprets press/release timing into discrete events.
// PARAMETERS
//  CNT_W          26          width of debounce and gesture timers
//  DEBOUNCE_CYC   500_000     cycles raw input must be stable to change btn_level (10 ms @ 50 MHz)
//  LONG_CYC       50_000_000  cycles held before long_evt (1 s @ 50 MHz)
//  GAP_CYC        12_500_000  max released gap between presses for double-click (250 ms)
//  Constraint: 2 <= each *_CYC < 2**CNT_W.
// PORTS
//  uclock         in   1  system clock; all logic on posedge
//  reset          in   1  asynchronous, active-high reset
//  btn_raw        in   1  raw button pin, asynchronous to uclock, 1 = pressed
//  btn_level      out  1  debounced, synchronized button level
//  press_evt      out  1  1-cycle pulse: debounced press
//  release_evt    out  1  1-cycle pulse: debounced release
//  click_evt      out  1  1-cycle pulse: single short click confirmed
//  dbl_click_evt  out  1  1-cycle pulse: double click confirmed
//  long_evt       out  1  1-cycle pulse: hold reached LONG_CYC
// BEHAVIOUR
//  Reset: all outputs 0, sync FFs 0, timers 0, FSM IDLE. Mid-gesture reset drops
//   the gesture; no event is emitted for it. Button held through reset release
//   debounces to 1 and yields a normal press_evt.
//  Sync: 2-FF synchronizer on btn_raw -> s. No other logic samples btn_raw.
//  Debounce: counter db clears whenever s == btn_level; otherwise increments.
//   When db reaches DEBOUNCE_CYC-1 with s != btn_level, btn_level <= s and db <= 0.
//   A stable raw change reaches btn_level DEBOUNCE_CYC+2 cycles later (+1 for sync sampling).
//  Edges: rise/fall detected from a registered copy of btn_level. Each event output
//   is registered and asserts exactly 1 cycle after the btn_level edge or timer
//   hit that causes it.
//  Gesture FSM (timer t clears on every state entry, increments otherwise,
//   saturates at all-ones):
//   IDLE     : rise -> press_evt, DOWN1
//   DOWN1    : fall -> release_evt, GAP; t==LONG_CYC-1 while held -> long_evt, LONGH
//   GAP      : rise -> press_evt, DOWN2; t==GAP_CYC-1 -> click_evt, IDLE
//   DOWN2    : fall -> release_evt + dbl_click_evt same cycle, IDLE;
//              t==LONG_CYC-1 -> long_evt, LONGH (no click, no dbl)
//   LONGH    : fall -> release_evt, IDLE; no further events while held
//  Simultaneous: in GAP, rise on the same cycle as timeout -> rise wins (press_evt,
//   DOWN2, no click_evt). In DOWN1/DOWN2, fall on the same cycle as long timeout
//   -> fall wins.
//  Exactly one of click/dbl/long per gesture; press_evt and release_evt never
//   assert in the same cycle. A third quick press after dbl_click starts a new
//   gesture from IDLE.
// TESTING (bench params: DEBOUNCE_CYC=4, LONG_CYC=40, GAP_CYC=20, CNT_W=8)
//  1 Bounce: raw pulses of 1-3 cycles high -> btn_level stays 0, no events.
//  2 Single click: raw high 10 cycles, low -> press_evt, release_evt, then
//    click_evt exactly 20 cycles after the GAP entry; btn_level tracks.
//  3 Double click: high 10 / low 8 / high 10 / low -> press, release, press,
//    then release_evt + dbl_click_evt same cycle; no click_evt.
//  4 Long press: high 60 cycles -> long_evt 40 cycles after press_evt; release
//    -> release_evt only, no click.
//  5 Reset mid-DOWN1: assert reset 15 cycles into a hold -> all outputs 0
//    immediately (async); release reset with raw low -> no events.
//  6 Race: debounced rise lands on GAP t==19 -> press_evt, no click_evt; next
//    release -> dbl_click_evt.

Source files
------------

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced button level plus press/release/click/double/long gesture events
module button_event_decoder #(
  parameter int CNT_W        = 26,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int GAP_CYC      = 12_500_000
) (
  input  logic uclock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_evt,
  output logic release_evt,
  output logic click_evt,
  output logic dbl_click_evt,
  output logic long_evt
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DOWN1 = 3'd1,
    GAP   = 3'd2,
    DOWN2 = 3'd3,
    LONGH = 3'd4
  } state_t;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] db;
  logic             level_q;
  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] t;
  logic             press_n;
  logic             release_n;
  logic             click_n;
  logic             dbl_n;
  logic             long_n;

  // btn_raw is asynchronous; only sync1 ever samples it
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      db        <= '0;
      btn_level <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      level_q <= btn_level;
      if (sync2 == btn_level) begin
        db <= '0;
      end else if (db == DB_LAST) begin
        btn_level <= sync2;
        db        <= '0;
      end else begin
        db <= db + ONE;
      end
    end
  end

  assign rise = btn_level & ~level_q;
  assign fall = ~btn_level & level_q;

  // Edges are checked before timeouts so a coincident edge always wins
  always_comb begin
    state_n   = state;
    press_n   = 1'b0;
    release_n = 1'b0;
    click_n   = 1'b0;
    dbl_n     = 1'b0;
    long_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          press_n = 1'b1;
          state_n = DOWN1;
        end
      end
      DOWN1: begin
        if (fall) begin
          release_n = 1'b1;
          state_n   = GAP;
        end else if (t == LONG_LAST) begin
          long_n  = 1'b1;
          state_n = LONGH;
        end
      end
      GAP: begin
        if (rise) begin
          press_n = 1'b1;
          state_n = DOWN2;
        end else if (t == GAP_LAST) begin
          click_n = 1'b1;
          state_n = IDLE;
        end
      end
      DOWN2: begin
        if (fall) begin
          release_n = 1'b1;
          dbl_n     = 1'b1;
          state_n   = IDLE;
        end else if (t == LONG_LAST) begin
          long_n  = 1'b1;
          state_n = LONGH;
        end
      end
      LONGH: begin
        if (fall) begin
          release_n = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      t             <= '0;
      press_evt     <= 1'b0;
      release_evt   <= 1'b0;
      click_evt     <= 1'b0;
      dbl_click_evt <= 1'b0;
      long_evt      <= 1'b0;
    end else begin
      state         <= state_n;
      press_evt     <= press_n;
      release_evt   <= release_n;
      click_evt     <= click_n;
      dbl_click_evt <= dbl_n;
      long_evt      <= long_n;
      if (state_n != state) begin
        t <= '0;
      end else if (t != '1) begin
        t <= t + ONE;
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - randomized and directed gesture checks against a timestamp-based reference model
module tb_button_event_decoder;
  localparam int D    = 4;
  localparam int LONG = 40;
  localparam int GAP  = 20;
  localparam int CW   = 8;
  localparam int HN   = 16384;

  logic uclock = 1'b0;
  logic reset  = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press_evt, release_evt, click_evt, dbl_click_evt, long_evt;

  button_event_decoder #(
    .CNT_W(CW), .DEBOUNCE_CYC(D), .LONG_CYC(LONG), .GAP_CYC(GAP)
  ) dut (
    .uclock(uclock), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_evt(press_evt), .release_evt(release_evt),
    .click_evt(click_evt), .dbl_click_evt(dbl_click_evt), .long_evt(long_evt)
  );

  always #5 uclock = ~uclock;

  int checks = 0;
  int failures = 0;
  int cyc_n = 16;
  bit raw_h [HN];
  bit lv_h  [HN];

  // Reference gesture: held flag, press count within the gesture, long flag, phase start cycle
  bit   m_held;
  int   m_presses;
  bit   m_long_done;
  int   m_start;
  logic [5:0] exp_vec;

  int n_press, n_rel, n_click, n_dbl, n_long, n_both, n_lvl_hi, n_mism;
  int c_press, c_rel, c_click, c_dbl, c_long, f_rel, mism_cyc;
  logic [5:0] mism_act, mism_exp;

  function automatic logic [5:0] obs();
    return {btn_level, press_evt, release_evt, click_evt, dbl_click_evt, long_evt};
  endfunction

  task automatic clear_obs();
    n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0; n_both = 0;
    n_lvl_hi = 0; n_mism = 0; c_press = -1; c_rel = -1; c_click = -1;
    c_dbl = -1; c_long = -1; f_rel = -1; mism_cyc = -1; mism_act = '0; mism_exp = '0;
  endtask

  // Called at the start of cycle cyc_n: apply the decision taken in cycle cyc_n-1,
  // then derive this cycle's debounced level from the raw history window.
  task automatic model_advance();
    int p, d;
    bit rise, fall, flip, ep, er, ec, ed, el;
    p = cyc_n - 1;
    rise = lv_h[p] && !lv_h[p-1];
    fall = !lv_h[p] && lv_h[p-1];
    d = p - m_start;
    ep = 0; er = 0; ec = 0; ed = 0; el = 0;
    if (!m_held) begin
      if (rise) begin
        ep = 1; m_held = 1; m_presses++; m_long_done = 0; m_start = cyc_n;
      end else if (m_presses == 1 && d == GAP - 1) begin
        ec = 1; m_presses = 0; m_start = cyc_n;
      end
    end else begin
      if (fall) begin
        er = 1; m_held = 0;
        if (!m_long_done && m_presses == 2) ed = 1;
        if (m_long_done || m_presses == 2) m_presses = 0;
        m_start = cyc_n;
      end else if (!m_long_done && d == LONG - 1) begin
        el = 1; m_long_done = 1; m_start = cyc_n;
      end
    end
    flip = 1;
    for (int m = 0; m < D; m++) if (raw_h[cyc_n-3-m] == lv_h[p]) flip = 0;
    lv_h[cyc_n] = flip ? !lv_h[p] : lv_h[p];
    exp_vec = {lv_h[cyc_n], ep, er, ec, ed, el};
  endtask

  task automatic step(input logic v);
    logic [5:0] o;
    btn_raw = v;
    raw_h[cyc_n] = v;
    @(posedge uclock); #1;
    cyc_n++;
    model_advance();
    o = obs();
    if (o !== exp_vec) begin
      if (n_mism == 0) begin mism_cyc = cyc_n; mism_act = o; mism_exp = exp_vec; end
      n_mism++;
    end
    if (btn_level) n_lvl_hi++;
    if (press_evt) begin n_press++; c_press = cyc_n; end
    if (release_evt) begin n_rel++; c_rel = cyc_n; if (f_rel < 0) f_rel = cyc_n; end
    if (click_evt) begin n_click++; c_click = cyc_n; end
    if (dbl_click_evt) begin n_dbl++; c_dbl = cyc_n; end
    if (long_evt) begin n_long++; c_long = cyc_n; end
    if (press_evt && release_evt) n_both++;
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic assert_reset(input logic v);
    reset = 1'b1;
    btn_raw = v;
    #2;
  endtask

  task automatic release_reset();
    repeat (3) begin @(posedge uclock); #1; end
    cyc_n += 3;
    for (int k = 0; k <= 10; k++) begin raw_h[cyc_n-k] = 0; lv_h[cyc_n-k] = 0; end
    reset = 1'b0;
    m_held = 0; m_presses = 0; m_long_done = 0; m_start = cyc_n;
    exp_vec = '0;
  endtask

  task automatic test_reset();
    btn_raw = 1'b0;
    reset = 1'b1;
    @(posedge uclock); #1;
    checks++;
    if (obs() !== 6'b0) begin failures++; $display("FAIL reset_outputs got=%b want=000000", obs()); end
    release_reset();
    clear_obs();
    drive(0, 30);
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_bounce();
    drive(0, 40);
    clear_obs();
    repeat (40) begin
      drive(1, $urandom_range(1, 3));
      drive(0, $urandom_range(1, 4));
    end
    drive(0, 20);
    checks++;
    if (n_lvl_hi !== 0) begin failures++; $display("FAIL bounce_level high_cycles=%0d want=0", n_lvl_hi); end
    checks++;
    if (n_press + n_rel + n_click + n_dbl + n_long !== 0) begin
      failures++; $display("FAIL bounce_events got=%0d want=0", n_press + n_rel + n_click + n_dbl + n_long);
    end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL bounce_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_single_click();
    int r0;
    drive(0, 40);
    clear_obs();
    r0 = cyc_n;
    drive(1, 10);
    drive(0, 40);
    checks++;
    if (n_press !== 1 || c_press !== r0 + D + 3) begin
      failures++; $display("FAIL click_press count=%0d at=%0d want=1 at %0d", n_press, c_press, r0 + D + 3);
    end
    checks++;
    if (n_rel !== 1 || c_rel !== r0 + 10 + D + 3) begin
      failures++; $display("FAIL click_release count=%0d at=%0d want=1 at %0d", n_rel, c_rel, r0 + 10 + D + 3);
    end
    checks++;
    if (n_click !== 1 || c_click !== c_rel + GAP) begin
      failures++; $display("FAIL click_timing count=%0d at=%0d want=1 at %0d", n_click, c_click, c_rel + GAP);
    end
    checks++;
    if (n_dbl !== 0 || n_long !== 0) begin failures++; $display("FAIL click_other dbl=%0d long=%0d want=0/0", n_dbl, n_long); end
    checks++;
    if (n_lvl_hi !== 10) begin failures++; $display("FAIL click_level high_cycles=%0d want=10", n_lvl_hi); end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL click_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_double_click();
    drive(0, 40);
    clear_obs();
    drive(1, 10); drive(0, 8); drive(1, 10); drive(0, 40);
    checks++;
    if (n_press !== 2 || n_rel !== 2) begin failures++; $display("FAIL dbl_counts press=%0d rel=%0d want=2/2", n_press, n_rel); end
    checks++;
    if (n_dbl !== 1 || c_dbl !== c_rel) begin failures++; $display("FAIL dbl_timing count=%0d at=%0d want=1 at %0d", n_dbl, c_dbl, c_rel); end
    checks++;
    if (n_click !== 0 || n_long !== 0) begin failures++; $display("FAIL dbl_other click=%0d long=%0d want=0/0", n_click, n_long); end
    checks++;
    if (n_both !== 0) begin failures++; $display("FAIL dbl_press_release_overlap got=%0d want=0", n_both); end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL dbl_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_long_press();
    drive(0, 40);
    clear_obs();
    drive(1, 60);
    drive(0, 40);
    checks++;
    if (n_long !== 1 || c_long !== c_press + LONG) begin
      failures++; $display("FAIL long_timing count=%0d at=%0d want=1 at %0d", n_long, c_long, c_press + LONG);
    end
    checks++;
    if (n_press !== 1 || n_rel !== 1) begin failures++; $display("FAIL long_counts press=%0d rel=%0d want=1/1", n_press, n_rel); end
    checks++;
    if (n_click !== 0 || n_dbl !== 0) begin failures++; $display("FAIL long_other click=%0d dbl=%0d want=0/0", n_click, n_dbl); end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL long_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_reset_mid();
    int r0;
    drive(0, 40);
    clear_obs();
    drive(1, 15);
    checks++;
    if (btn_level !== 1'b1 || n_press !== 1) begin failures++; $display("FAIL rmid_setup level=%b press=%0d want=1/1", btn_level, n_press); end
    assert_reset(1'b0);
    checks++;
    if (obs() !== 6'b0) begin failures++; $display("FAIL rmid_async got=%b want=000000", obs()); end
    release_reset();
    clear_obs();
    drive(0, 50);
    checks++;
    if (n_press + n_rel + n_click + n_dbl + n_long + n_lvl_hi !== 0) begin
      failures++; $display("FAIL rmid_quiet got=%0d want=0", n_press + n_rel + n_click + n_dbl + n_long + n_lvl_hi);
    end
    drive(1, 10);
    assert_reset(1'b1);
    checks++;
    if (obs() !== 6'b0) begin failures++; $display("FAIL rheld_async got=%b want=000000", obs()); end
    release_reset();
    clear_obs();
    r0 = cyc_n;
    drive(1, 20);
    drive(0, 40);
    checks++;
    if (n_press !== 1 || c_press !== r0 + D + 3) begin
      failures++; $display("FAIL rheld_press count=%0d at=%0d want=1 at %0d", n_press, c_press, r0 + D + 3);
    end
    checks++;
    if (n_click !== 1 || n_rel !== 1) begin failures++; $display("FAIL rheld_click click=%0d rel=%0d want=1/1", n_click, n_rel); end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL rheld_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_race();
    drive(0, 40);
    clear_obs();
    drive(1, 10); drive(0, 20); drive(1, 10); drive(0, 40);
    checks++;
    if (c_press !== f_rel + GAP) begin failures++; $display("FAIL race_landing press_at=%0d want=%0d", c_press, f_rel + GAP); end
    checks++;
    if (n_click !== 0 || n_dbl !== 1) begin failures++; $display("FAIL race_events click=%0d dbl=%0d want=0/1", n_click, n_dbl); end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL race_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
    drive(0, 20);
    clear_obs();
    drive(1, 10); drive(0, 21); drive(1, 10); drive(0, 40);
    checks++;
    if (n_click !== 2 || n_dbl !== 0 || n_press !== 2) begin
      failures++; $display("FAIL race_late click=%0d dbl=%0d press=%0d want=2/0/2", n_click, n_dbl, n_press);
    end
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL race_late_model cyc=%0d got=%b want=%b", mism_cyc, mism_act, mism_exp); end
  endtask

  task automatic test_back_to_back();
    logic v;
    drive(0, 40);
    clear_obs();
    v = 1'b1;
    repeat (150) begin
      case ($urandom_range(0, 3))
        0:       drive(v, $urandom_range(1, 5));
        1:       drive(v, $urandom_range(5, 25));
        2:       drive(v, $urandom_range(15, 30));
        default: drive(v, $urandom_range(30, 70));
      endcase
      v = ~v;
    end
    drive(0, 60);
    checks++;
    if (n_mism !== 0) begin failures++; $display("FAIL random_model mism=%0d cyc=%0d got=%b want=%b", n_mism, mism_cyc, mism_act, mism_exp); end
    checks++;
    if (n_both !== 0) begin failures++; $display("FAIL random_overlap got=%0d want=0", n_both); end
    checks++;
    if (n_press !== n_rel) begin failures++; $display("FAIL random_balance press=%0d rel=%0d want equal", n_press, n_rel); end
  endtask

  initial begin
    m_held = 0; m_presses = 0; m_long_done = 0; m_start = 0; exp_vec = '0;
    clear_obs();
    test_reset();
    test_bounce();
    test_single_click();
    test_double_click();
    test_long_press();
    test_reset_mid();
    test_race();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
